jelly_wb_cfg_sequencer: RTL



---
 rtl/jelly_wb_cfg_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jelly_wb_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// jelly_wb_cfg_sequencer
//
// Wishbone classic master that executes a stream of configuration commands
// (WRITE, READ, POLL-until-match, WAIT) on the peripheral register bus.
// It is used to bring up the video pipeline with a deterministic,
// hardware-timed register sequence.
//
// Optional feature macro: JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
//   When it is defined, a per-command watchdog aborts an ACCESS/POLL that
//   runs for TIMEOUT cycles and sets the sticky `error` flag.
//   When it is not defined, the sequencer waits indefinitely and `error` is 0.
//
// Ports:
//   clk, reset_n          : clock and asynchronous active-low reset
//   s_cmd_*               : command stream (op/adr/dat/mask/sel, valid/ready)
//   m_rd_dat, m_rd_valid  : last read data and one-cycle completion pulse
//   m_wb_*                : Wishbone classic master request/response
//   busy                  : high while not IDLE
//   error, clear_error    : sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module jelly_wb_cfg_sequencer #(
  parameter int WB_ADR_WIDTH  = 30,
  parameter int WB_DAT_WIDTH  = 64,
  parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter int CNT_WIDTH     = 24,
  parameter int POLL_INTERVAL = 16,
  parameter int TIMEOUT       = (1 << 20) - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              s_cmd_op,
  input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_mask,
  input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  output logic [WB_DAT_WIDTH-1:0] m_rd_dat,
  output logic                    m_rd_valid,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  input  logic                    m_wb_ack_i,
  output logic                    busy,
  output logic                    error,
  input  logic                    clear_error
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_POLL_GAP = 2'd2,
    ST_DELAY    = 2'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_WAIT  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(POLL_INTERVAL);

  state_t                  state_reg,   state_next;
  logic [1:0]              op_reg,      op_next;
  logic [WB_ADR_WIDTH-1:0] adr_reg,     adr_next;
  logic [WB_DAT_WIDTH-1:0] dat_o_reg,   dat_o_next;
  logic [WB_SEL_WIDTH-1:0] sel_reg,     sel_next;
  logic                    we_reg,      we_next;
  logic                    stb_reg,     stb_next;
  logic [WB_DAT_WIDTH-1:0] mask_reg,    mask_next;
  logic [WB_DAT_WIDTH-1:0] exp_reg,     exp_next;
  logic [CNT_WIDTH-1:0]    cnt_reg,     cnt_next;
  logic [WB_DAT_WIDTH-1:0] rd_dat_reg,  rd_dat_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    error_reg,   error_next;
`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  logic [CNT_WIDTH-1:0]    tmo_reg,     tmo_next;
`else
  // Watchdog inputs have no function in this build.
  logic unused_cfg;
  assign unused_cfg = clear_error | (TIMEOUT == 0);
`endif

  logic accept;
  logic poll_match;

  assign s_cmd_ready = (state_reg == ST_IDLE) && !error_reg;
  assign accept      = s_cmd_valid && s_cmd_ready;
  assign poll_match  = ((m_wb_dat_i & mask_reg) == (exp_reg & mask_reg));

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    adr_next      = adr_reg;
    dat_o_next    = dat_o_reg;
    sel_next      = sel_reg;
    we_next       = we_reg;
    stb_next      = stb_reg;
    mask_next     = mask_reg;
    exp_next      = exp_reg;
    cnt_next      = cnt_reg;
    rd_dat_next   = rd_dat_reg;
    rd_valid_next = 1'b0;
`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
    tmo_next      = tmo_reg;
    error_next    = error_reg && !clear_error;
`else
    error_next    = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next = s_cmd_op;
`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
          tmo_next = '0;
`endif
          if (s_cmd_op == OP_WAIT) begin
            // A zero count is a no-op and keeps the sequencer in IDLE.
            if (s_cmd_dat[CNT_WIDTH-1:0] != '0) begin
              cnt_next   = s_cmd_dat[CNT_WIDTH-1:0];
              state_next = ST_DELAY;
            end
          end else begin
            adr_next   = s_cmd_adr;
            we_next    = (s_cmd_op == OP_WRITE);
            sel_next   = (s_cmd_op == OP_WRITE) ? s_cmd_sel : '1;
            // Write data bus keeps its previous value for reads/polls.
            if (s_cmd_op == OP_WRITE) begin
              dat_o_next = s_cmd_dat;
            end
            mask_next  = s_cmd_mask;
            exp_next   = s_cmd_dat;
            stb_next   = 1'b1;
            state_next = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (m_wb_ack_i && stb_reg) begin
          stb_next = 1'b0;
          we_next  = 1'b0;
          if (op_reg != OP_WRITE) begin
            rd_dat_next = m_wb_dat_i;
          end
          if (op_reg == OP_POLL && !poll_match) begin
            cnt_next   = GAP_LOAD;
            state_next = ST_POLL_GAP;
          end else begin
            rd_valid_next = (op_reg != OP_WRITE);
            state_next    = ST_IDLE;
          end
        end
      end

      ST_POLL_GAP: begin
        // Exits after exactly POLL_INTERVAL cycles with stb low; address,
        // sel and we are unchanged from the previous poll read.
        if (cnt_reg <= CNT_ONE) begin
          cnt_next   = '0;
          stb_next   = 1'b1;
          state_next = ST_ACCESS;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_DELAY: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
    // Watchdog overrides whatever the FSM decided on the expiry edge, and a
    // simultaneous clear_error loses against the new timeout.
    if (state_reg == ST_ACCESS || state_reg == ST_POLL_GAP) begin
      tmo_next = tmo_reg + CNT_ONE;
      if (tmo_next == TIMEOUT_C) begin
        stb_next      = 1'b0;
        we_next       = 1'b0;
        rd_valid_next = 1'b0;
        cnt_next      = '0;
        error_next    = 1'b1;
        state_next    = ST_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= '0;
      adr_reg      <= '0;
      dat_o_reg    <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      stb_reg      <= 1'b0;
      mask_reg     <= '0;
      exp_reg      <= '0;
      cnt_reg      <= '0;
      rd_dat_reg   <= '0;
      rd_valid_reg <= 1'b0;
      error_reg    <= 1'b0;
`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
      tmo_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      adr_reg      <= adr_next;
      dat_o_reg    <= dat_o_next;
      sel_reg      <= sel_next;
      we_reg       <= we_next;
      stb_reg      <= stb_next;
      mask_reg     <= mask_next;
      exp_reg      <= exp_next;
      cnt_reg      <= cnt_next;
      rd_dat_reg   <= rd_dat_next;
      rd_valid_reg <= rd_valid_next;
      error_reg    <= error_next;
`ifdef JELLY_WB_CFG_SEQUENCER_TIMEOUT_EN
      tmo_reg      <= tmo_next;
`endif
    end
  end

  assign m_wb_adr_o = adr_reg;
  assign m_wb_dat_o = dat_o_reg;
  assign m_wb_sel_o = sel_reg;
  assign m_wb_we_o  = we_reg;
  assign m_wb_stb_o = stb_reg;
  assign m_rd_dat   = rd_dat_reg;
  assign m_rd_valid = rd_valid_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign error      = error_reg;

endmodule
